dir_enable_init_seq: RTL

DIR_ENABLE_INIT_SEQ -- requirements
Module: dir_enable_init_seq

---
 rtl/dir_enable_init_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dir_enable_init_seq.sv
// Post-reset enable sequencer: SFER, CASER0/1/3 and MRHER register writes.
// Define DIR_INIT_READBACK_EN to verify every write with a read-back.
`timescale 1ns/1ps
module dir_enable_init_seq #(
  parameter int          NUM_SF      = 4,
  parameter int          NUM_CAIU    = 40,
  parameter int          NUM_BAIU    = 0,
  parameter int          NUM_MRH     = 2,
  parameter int          HOLD_CYCLES = 200,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [11:0] ADDR_SFER   = 12'h040,
  parameter logic [11:0] ADDR_CASER0 = 12'h080,
  parameter logic [11:0] ADDR_CASER1 = 12'h084,
  parameter logic [11:0] ADDR_CASER3 = 12'h08C,
  parameter logic [11:0] ADDR_MRHER  = 12'h0C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        reg_req,
  output logic        reg_we,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);

`ifdef DIR_INIT_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_WR, S_RD, S_NEXT, S_DONE, S_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_WR, S_NEXT, S_DONE, S_ERR
  } state_e;
`endif

  localparam int N_CAIU0 = (NUM_CAIU > 32) ? 32 : NUM_CAIU;
  localparam int N_CAIU1 = (NUM_CAIU > 32) ? NUM_CAIU - 32 : 0;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

  function automatic logic [31:0] ones(input int n);
    logic [31:0] r;
    if (n >= 32)     r = '1;
    else if (n <= 0) r = '0;
    else             r = (32'h1 << n) - 32'h1;
    return r;
  endfunction

  function automatic logic [11:0] step_addr(input logic [2:0] s);
    logic [11:0] r;
    r = ADDR_MRHER;
    case (s)
      3'd0:    r = ADDR_SFER;
      3'd1:    r = ADDR_CASER0;
      3'd2:    r = ADDR_CASER1;
      3'd3:    r = ADDR_CASER3;
      default: r = ADDR_MRHER;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] step_data(input logic [2:0] s);
    logic [31:0] r;
    r = '0;
    case (s)
      3'd0:    r = ones(NUM_SF);
      3'd1:    r = ones(N_CAIU0);
      3'd2:    r = ones(N_CAIU1);
      3'd3:    r = ones(NUM_BAIU);
      default: r = ones(NUM_MRH);
    endcase
    return r;
  endfunction

  // Skipped steps fold into the same NEXT cycle, so they cost nothing.
  function automatic logic [2:0] step_after(input logic [2:0] s);
    logic [2:0] n;
    n = s + 3'd1;
    if (n == 3'd2 && NUM_CAIU <= 32) n = 3'd3;
    if (n == 3'd3 && NUM_BAIU == 0)  n = 3'd4;
    return n;
  endfunction

  state_e      state_q;
  logic [2:0]  step_q;
  logic [2:0]  step_d;
  logic [2:0]  go_step_d;
  logic        go_d;
  logic [15:0] cnt_q;
  logic        req_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  ecode_q;
  logic        rd_go;

`ifdef DIR_INIT_READBACK_EN
  logic rd_pend_q;
  logic rb_bad;
  assign rd_go  = rd_pend_q;
  // wdata_q is exactly the low-N ones mask of the step under check
  assign rb_bad = (reg_rdata & wdata_q) != wdata_q;
`else
  logic unused_rdata;
  assign rd_go        = 1'b0;
  assign unused_rdata = ^reg_rdata;
`endif

  always_comb begin
    step_d    = step_after(step_q);
    go_d      = 1'b0;
    go_step_d = 3'd0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: go_d = start;
      S_HOLD: go_d = (cnt_q == HOLD_LAST);
      S_NEXT: begin
        go_d      = !rd_go && (step_d <= 3'd4);
        go_step_d = step_d;
      end
      default: go_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= '0;
`ifdef DIR_INIT_READBACK_EN
      rd_pend_q <= 1'b0;
`endif
    end else if (go_d) begin
      state_q <= S_WR;
      step_q  <= go_step_d;
      cnt_q   <= '0;
      req_q   <= 1'b1;
      we_q    <= 1'b1;
      addr_q  <= step_addr(go_step_d);
      wdata_q <= step_data(go_step_d);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= '0;
`ifdef DIR_INIT_READBACK_EN
      rd_pend_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_HOLD;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        S_HOLD: cnt_q <= cnt_q + 16'd1;
        S_WR: begin
          if (reg_ack && req_q) begin
            req_q   <= 1'b0;
            state_q <= S_NEXT;
`ifdef DIR_INIT_READBACK_EN
            rd_pend_q <= 1'b1;
`endif
          end else if (cnt_q == ACK_LAST) begin
            req_q   <= 1'b0;
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            ecode_q <= step_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef DIR_INIT_READBACK_EN
        S_RD: begin
          if (reg_ack && req_q) begin
            req_q <= 1'b0;
            if (rb_bad) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              ecode_q <= step_q;
            end else begin
              state_q   <= S_NEXT;
              rd_pend_q <= 1'b0;
            end
          end else if (cnt_q == ACK_LAST) begin
            req_q   <= 1'b0;
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            ecode_q <= step_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        S_NEXT: begin
`ifdef DIR_INIT_READBACK_EN
          if (rd_go) begin
            state_q <= S_RD;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= '0;
          end else
`endif
          begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign reg_req   = req_q;
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = ecode_q;

endmodule
